// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator for the instruction-fetch stage
//
// Drives the fetch address every cycle. Sequential advance by STEP under a
// valid/ready handshake, prioritised redirects (exception > branch/call >
// return) and an optional return-address stack.
//
// Optional feature macro: PC_RAS_EN
//   defined   : RAS of RAS_DEPTH entries; calls push i_link, returns pop.
//   undefined : no RAS; i_call/i_link/i_ret ignored, o_ras_empty=1, o_ras_err=0.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   i_ready      in   fetch accepts o_pc this cycle
//   i_stall      in   freeze sequential advance
//   i_halt       in   enter HALT after the current PC is accepted
//   i_exc        in   redirect to EXC_VEC
//   i_br_taken   in   redirect to i_br_target
//   i_br_target  in   branch/call target [N]
//   i_call       in   branch is a call; push i_link
//   i_link       in   return address to push [N]
//   i_ret        in   return; pop RAS top as target
//   o_pc         out  current fetch PC (registered) [N]
//   o_valid      out  o_pc is a valid fetch request
//   o_ras_empty  out  RAS holds no entries
//   o_ras_err    out  one-cycle pulse: return seen on empty RAS

module pc_gen #(
  parameter int           N         = 32,
  parameter logic [N-1:0] RESET_PC  = '0,
  parameter logic [N-1:0] EXC_VEC   = N'(8),
  parameter logic [N-1:0] STEP      = N'(4),
  parameter int           RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ready,
  input  logic         i_stall,
  input  logic         i_halt,
  input  logic         i_exc,
  input  logic         i_br_taken,
  input  logic [N-1:0] i_br_target,
  input  logic         i_call,
  input  logic [N-1:0] i_link,
  input  logic         i_ret,
  output logic [N-1:0] o_pc,
  output logic         o_valid,
  output logic         o_ras_empty,
  output logic         o_ras_err
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pc_d;
  logic         err_d;
  logic         advance;

  assign advance = i_ready & ~i_stall;
  assign o_valid = (state_q == RUN);

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);

  // ras_ptr_q points at the next free slot; the top is the slot below it.
  // Writing through the pointer on a full stack overwrites the oldest entry.
  logic [N-1:0]     ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_q;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W:0]   ras_cnt_q;
  logic [N-1:0]     ras_top;
  logic             ras_empty;
  logic             push, pop;

  assign top_idx     = ras_ptr_q - PTR_W'(1);
  assign ras_top     = ras_mem[top_idx];
  assign ras_empty   = (ras_cnt_q == '0);
  assign o_ras_empty = ras_empty;
`else
  logic unused_ras;
  assign unused_ras  = ^{i_call, i_link, i_ret, err_d};
  assign o_ras_empty = 1'b1;
  assign o_ras_err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = o_pc;
    err_d   = 1'b0;
`ifdef PC_RAS_EN
    push    = 1'b0;
    pop     = 1'b0;
`endif
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (i_exc) begin
          pc_d = EXC_VEC;
        end else if (i_br_taken) begin
          pc_d = i_br_target;
`ifdef PC_RAS_EN
          push = i_call;
        end else if (i_ret && !ras_empty) begin
          pop  = 1'b1;
          pc_d = ras_top;
`endif
        end else begin
          // Reaching here with i_ret set means the RAS was empty: flag it
          // and fall through to the ordinary advance/hold behaviour.
          err_d = i_ret;
          if (advance) begin
            pc_d = o_pc + STEP;
            if (i_halt) state_d = HALT;
          end
        end
      end
      HALT: begin
        if (i_exc) begin
          state_d = RUN;
          pc_d    = EXC_VEC;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      o_pc    <= RESET_PC;
    end else begin
      state_q <= state_d;
      o_pc    <= pc_d;
    end
  end

`ifdef PC_RAS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
      o_ras_err <= 1'b0;
    end else begin
      o_ras_err <= err_d;
      if (push) begin
        ras_ptr_q <= ras_ptr_q + PTR_W'(1);
        if (ras_cnt_q != (PTR_W+1)'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + 1'b1;
      end else if (pop) begin
        ras_ptr_q <= top_idx;
        ras_cnt_q <= ras_cnt_q - 1'b1;
      end
    end
  end

  // Entry storage needs no reset: the count alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) ras_mem[ras_ptr_q] <= i_link;
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard testbench for pc_gen
module tb_pc_gen;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_ready, i_stall, i_halt, i_exc, i_br_taken, i_call, i_ret;
  logic [31:0] i_br_target, i_link;
  logic [31:0] o_pc;
  logic        o_valid, o_ras_empty, o_ras_err;

  logic        one1  = 1'b1;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = '0;
  logic [31:0] w_pc;
  logic        w_valid, w_empty, w_err;

  always #5 clk = ~clk;

  pc_gen #(.N(32), .RESET_PC(32'h100), .EXC_VEC(32'h8), .STEP(32'h4), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_ready(i_ready), .i_stall(i_stall), .i_halt(i_halt),
    .i_exc(i_exc), .i_br_taken(i_br_taken), .i_br_target(i_br_target),
    .i_call(i_call), .i_link(i_link), .i_ret(i_ret),
    .o_pc(o_pc), .o_valid(o_valid), .o_ras_empty(o_ras_empty), .o_ras_err(o_ras_err)
  );

  pc_gen #(.N(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .i_ready(one1), .i_stall(zero1), .i_halt(zero1),
    .i_exc(zero1), .i_br_taken(zero1), .i_br_target(zero32),
    .i_call(zero1), .i_link(zero32), .i_ret(zero1),
    .o_pc(w_pc), .o_valid(w_valid), .o_ras_empty(w_empty), .o_ras_err(w_err)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        valid;
    logic        empty;
    logic        err;
    logic        wchk;
    logic [31:0] wpc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        wchk_g = 1'b0;
  logic [31:0] wpc_g  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    chk({e.name, "/pc"},    o_pc,               e.pc);
    chk({e.name, "/valid"}, {31'd0, o_valid},     {31'd0, e.valid});
    chk({e.name, "/empty"}, {31'd0, o_ras_empty}, {31'd0, e.empty});
    chk({e.name, "/err"},   {31'd0, o_ras_err},   {31'd0, e.err});
    if (e.wchk) chk({e.name, "/wrap_pc"}, w_pc, e.wpc);
  endtask

  // Monitor: one expectation per clock edge, plus one on each reset assertion.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) compare(sb.pop_front());
  end

  always @(negedge rst) begin
    #1;
    if (sb.size() != 0) compare(sb.pop_front());
  end

  task automatic push_exp(input string nm, input logic [31:0] pc, input logic v,
                          input logic em, input logic er);
    exp_t e;
    e.name = nm; e.pc = pc; e.valid = v; e.empty = em; e.err = er;
    e.wchk = wchk_g; e.wpc = wpc_g;
    sb.push_back(e);
  endtask

  task automatic tick(input string nm, input logic [31:0] pc, input logic v,
                      input logic em, input logic er);
    push_exp(nm, pc, v, em, er);
    @(negedge clk);
  endtask

  initial begin
    i_ready = 0; i_stall = 0; i_halt = 0; i_exc = 0; i_br_taken = 0;
    i_call = 0; i_ret = 0; i_br_target = '0; i_link = '0;
    @(negedge clk);

    push_exp("rst_async", 32'h100, 0, 1, 0);
    rst = 1'b0;
    tick("rst_hold", 32'h100, 0, 1, 0);

    rst = 1'b1; i_ready = 1;
    wchk_g = 1; wpc_g = 32'hFFFF_FFF8;
    tick("boot_exit", 32'h100, 1, 1, 0);
    wpc_g = 32'hFFFF_FFFC;
    tick("seq_104", 32'h104, 1, 1, 0);
    wpc_g = 32'h0000_0000;
    tick("seq_108", 32'h108, 1, 1, 0);
    wchk_g = 0;

    i_stall = 1;
    tick("stall_1", 32'h108, 1, 1, 0);
    i_br_taken = 1; i_br_target = 32'h400;
    tick("stall_br", 32'h400, 1, 1, 0);
    i_br_taken = 0;
    tick("stall_3", 32'h400, 1, 1, 0);
    i_stall = 0; i_ready = 0;
    tick("not_ready", 32'h400, 1, 1, 0);

    i_ready = 1; i_exc = 1; i_br_taken = 1; i_br_target = 32'h500; i_ret = 1;
    tick("exc_prio", 32'h8, 1, 1, 0);
    i_exc = 0; i_br_taken = 0; i_ret = 0;

    for (int i = 1; i <= 5; i++) begin
      i_br_taken = 1; i_call = 1; i_br_target = 32'h1000; i_link = 32'(16 * i);
      tick($sformatf("call_%0d", i), 32'h1000, 1, !RAS, 0);
    end
    i_br_taken = 0; i_call = 0;

    i_ret = 1;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] epc;
      if (RAS) epc = (i < 4) ? 32'(32'h50 - 16 * i) : 32'h24;
      else     epc = 32'(32'h1004 + 4 * i);
      tick($sformatf("ret_%0d", i + 1), epc, 1, !RAS || (i >= 3), RAS && (i == 4));
    end
    i_ret = 0;
    tick("err_clear", RAS ? 32'h28 : 32'h1018, 1, 1, 0);

    i_br_taken = 1; i_br_target = 32'h200;
    tick("br_200", 32'h200, 1, 1, 0);
    i_br_taken = 0; i_halt = 1;
    tick("halt_acc", 32'h204, 0, 1, 0);
    i_halt = 0;
    for (int i = 0; i < 10; i++) begin
      i_br_taken = (i == 4); i_br_target = 32'h600; i_ret = (i == 6);
      tick($sformatf("halt_hold_%0d", i), 32'h204, 0, 1, 0);
    end
    i_br_taken = 0; i_ret = 0; i_exc = 1;
    tick("halt_exc", 32'h8, 1, 1, 0);
    i_exc = 0; i_halt = 1; i_stall = 1;
    tick("halt_stalled", 32'h8, 1, 1, 0);
    i_halt = 0; i_stall = 0;
    tick("resume_seq", 32'hC, 1, 1, 0);

    i_br_taken = 1; i_call = 1; i_br_target = 32'h300; i_link = 32'h70;
    tick("call_pre_rst", 32'h300, 1, !RAS, 0);
    i_br_taken = 0; i_call = 0;

    push_exp("rst_mid_async", 32'h100, 0, 1, 0);
    rst = 1'b0;
    tick("rst_mid", 32'h100, 0, 1, 0);
    rst = 1'b1;
    tick("rst_boot", 32'h100, 1, 1, 0);
    i_ret = 1;
    tick("ret_after_rst", 32'h104, 1, 1, RAS);
    i_ret = 0;
    tick("ret_err_clear", 32'h108, 1, 1, 0);

    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
